// File: rtl/legv8_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// legv8_ctrl_pkg : shared types and encodings for the LEGv8 multi-cycle control
// Revision 1.0
// ============================================================================
package legv8_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_FETCH   = 4'd0,
        ST_DECODE  = 4'd1,
        ST_EX_R    = 4'd2,
        ST_WB_R    = 4'd3,
        ST_EX_ADDR = 4'd4,
        ST_MEM_RD  = 4'd5,
        ST_WB_LD   = 4'd6,
        ST_MEM_WR  = 4'd7,
        ST_EX_CBZ  = 4'd8,
        ST_EX_B    = 4'd9,
        ST_HALT    = 4'd10
    } state_e;

    typedef enum logic [2:0] {
        CLS_R    = 3'd0,
        CLS_LDUR = 3'd1,
        CLS_STUR = 3'd2,
        CLS_CBZ  = 3'd3,
        CLS_B    = 3'd4,
        CLS_ILL  = 3'd5
    } iclass_e;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;

    // CBZ and B carry immediate bits inside the 11-bit opcode field
    localparam logic [10:0] OP_CBZ_VAL  = 11'b10110100000;
    localparam logic [10:0] OP_CBZ_MASK = 11'b11111111000;
    localparam logic [10:0] OP_B_VAL    = 11'b00010100000;
    localparam logic [10:0] OP_B_MASK   = 11'b11111100000;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_ORR   = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_PASSB = 4'b0111;

    localparam logic [1:0] IMM_D  = 2'b00;
    localparam logic [1:0] IMM_CB = 2'b01;
    localparam logic [1:0] IMM_B  = 2'b10;

    function automatic logic op_match(input logic [10:0] op,
                                      input logic [10:0] val,
                                      input logic [10:0] mask);
        return (op & mask) == val;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ctrl_opdecode.sv
`default_nettype none
// ============================================================================
// ctrl_opdecode : combinational opcode classifier for the multi-cycle control
// Revision 1.0
// ============================================================================
module ctrl_opdecode
    import legv8_ctrl_pkg::*;
(
    input  logic [10:0] opcode_i,
    output iclass_e     iclass_o,
    output logic [3:0]  alu_ctl_o,
    output logic [1:0]  imm_sel_o,
    output logic        illegal_o
);

    always_comb begin
        iclass_o  = CLS_ILL;
        alu_ctl_o = ALU_ADD;
        imm_sel_o = IMM_D;
        if (opcode_i == OP_ADD) begin
            iclass_o = CLS_R;
        end else if (opcode_i == OP_SUB) begin
            iclass_o  = CLS_R;
            alu_ctl_o = ALU_SUB;
        end else if (opcode_i == OP_AND) begin
            iclass_o  = CLS_R;
            alu_ctl_o = ALU_AND;
        end else if (opcode_i == OP_ORR) begin
            iclass_o  = CLS_R;
            alu_ctl_o = ALU_ORR;
        end else if (opcode_i == OP_LDUR) begin
            iclass_o = CLS_LDUR;
        end else if (opcode_i == OP_STUR) begin
            iclass_o = CLS_STUR;
        end else if (op_match(opcode_i, OP_CBZ_VAL, OP_CBZ_MASK)) begin
            iclass_o  = CLS_CBZ;
            alu_ctl_o = ALU_PASSB;
            imm_sel_o = IMM_CB;
        end else if (op_match(opcode_i, OP_B_VAL, OP_B_MASK)) begin
            iclass_o  = CLS_B;
            imm_sel_o = IMM_B;
        end
        illegal_o = (iclass_o == CLS_ILL);
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// multicycle_ctrl : LEGv8 multi-cycle control FSM with ready-handshake memory
// Revision 1.0
// ============================================================================
module multicycle_ctrl
    import legv8_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [10:0] opcode,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        ir_we,
    output logic        pc_we,
    output logic        pc_src,
    output logic        reg2loc,
    output logic        reg_we,
    output logic        alu_src,
    output logic [3:0]  alu_ctl,
    output logic [1:0]  imm_sel,
    output logic        mem_read,
    output logic        mem_write,
    output logic        iord,
    output logic        mem_to_reg,
    output logic        retire,
    output logic        illegal
);

    state_e      state_q, state_d;
    logic        illegal_q, illegal_d;

    iclass_e     dec_class;
    logic [3:0]  dec_alu_ctl;
    logic [1:0]  dec_imm_sel;
    logic        dec_illegal;

    ctrl_opdecode u_opdecode (
        .opcode_i  (opcode),
        .iclass_o  (dec_class),
        .alu_ctl_o (dec_alu_ctl),
        .imm_sel_o (dec_imm_sel),
        .illegal_o (dec_illegal)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ST_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    // Reset gates every strobe off in the same cycle, whatever state we are in
    assign illegal = illegal_q & reset_n;

    always_comb begin
        state_d    = state_q;
        illegal_d  = illegal_q;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_src     = 1'b0;
        reg2loc    = 1'b0;
        reg_we     = 1'b0;
        alu_src    = 1'b0;
        alu_ctl    = ALU_AND;
        imm_sel    = IMM_D;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        iord       = 1'b0;
        mem_to_reg = 1'b0;
        retire     = 1'b0;

        if (!reset_n) begin
            state_d   = ST_FETCH;
            illegal_d = 1'b0;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    mem_read = 1'b1;
                    if (mem_ready) begin
                        ir_we   = 1'b1;
                        state_d = ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    imm_sel = dec_imm_sel;
                    reg2loc = (dec_class == CLS_STUR) || (dec_class == CLS_CBZ);
                    case (dec_class)
                        CLS_R:    state_d = ST_EX_R;
                        CLS_LDUR: state_d = ST_EX_ADDR;
                        CLS_STUR: state_d = ST_EX_ADDR;
                        CLS_CBZ:  state_d = ST_EX_CBZ;
                        CLS_B:    state_d = ST_EX_B;
                        default:  state_d = ST_HALT;
                    endcase
                    if (dec_illegal) begin
                        illegal_d = 1'b1;
                    end
                end
                ST_EX_R: begin
                    alu_ctl = dec_alu_ctl;
                    state_d = ST_WB_R;
                end
                ST_WB_R: begin
                    reg_we  = 1'b1;
                    pc_we   = 1'b1;
                    retire  = 1'b1;
                    state_d = ST_FETCH;
                end
                ST_EX_ADDR: begin
                    alu_src = 1'b1;
                    alu_ctl = ALU_ADD;
                    state_d = (dec_class == CLS_LDUR) ? ST_MEM_RD : ST_MEM_WR;
                end
                ST_MEM_RD: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                    if (mem_ready) begin
                        state_d = ST_WB_LD;
                    end
                end
                ST_WB_LD: begin
                    reg_we     = 1'b1;
                    mem_to_reg = 1'b1;
                    pc_we      = 1'b1;
                    retire     = 1'b1;
                    state_d    = ST_FETCH;
                end
                ST_MEM_WR: begin
                    mem_write = 1'b1;
                    iord      = 1'b1;
                    reg2loc   = 1'b1;
                    if (mem_ready) begin
                        pc_we   = 1'b1;
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end
                end
                ST_EX_CBZ: begin
                    alu_ctl = ALU_PASSB;
                    imm_sel = IMM_CB;
                    pc_we   = 1'b1;
                    pc_src  = zero;
                    retire  = 1'b1;
                    state_d = ST_FETCH;
                end
                ST_EX_B: begin
                    imm_sel = IMM_B;
                    pc_we   = 1'b1;
                    pc_src  = 1'b1;
                    retire  = 1'b1;
                    state_d = ST_FETCH;
                end
                ST_HALT: begin
                    state_d = ST_HALT;
                end
                default: begin
                    state_d = ST_FETCH;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
